// File: rtl/digit_serial_addsub_pkg.sv
// Shared state encoding and counter sizing for the digit-serial adder/subtractor.
package digit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit operation still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_addsub_digit.sv
// One DIGIT-bit ripple slice; also exposes the carry into its MSB for overflow.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic c;

    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output
        // gets a default before the loop so no path can infer a latch.
        s    = '0;
        c    = cin;
        cmsb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            cmsb = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: N = WIDTH/DIGIT cycles per operation, LSB slice first.
module digit_serial_addsub
    import digit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r, s_ext;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, ovf_r;
    logic [DIGIT-1:0] s_dig;
    logic             c_dig, cmsb_dig;
    logic             last, accept;

    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state != RUN);
    // The new slice enters at the top so that after N shifts it sits LSB-aligned.
    assign s_ext  = WIDTH'(s_dig) << (WIDTH - DIGIT);

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sr[DIGIT-1:0]),
        .y    (b_sr[DIGIT-1:0]),
        .cin  (carry),
        .s    (s_dig),
        .cout (c_dig),
        .cmsb (cmsb_dig)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        sum  = sum_r;
        cout = cout_r;
        ovf  = ovf_r;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with m.
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{m}};
            carry <= m;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            sum_r <= (sum_r >> DIGIT) | s_ext;
            carry <= c_dig;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout_r <= c_dig;
                ovf_r  <= c_dig ^ cmsb_dig;
            end
        end
    end

endmodule
